alu_seq_core: RTL and testbench
===============================

ALU_SEQ_CORE -- requirements
Module: alu_seq_core

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/result width (legal 4..32, power of two).
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), meaning shift-amount width taken from b[SHW-1:0].
REQ-003 SHALL have port clk  input  1  rising-edge clock; the block uses one clock.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  operation request.
REQ-006 SHALL have port in_ready  output  1  block can accept a request.
REQ-007 SHALL have port op  input  4  opcode.
REQ-008 SHALL have port a  input  WIDTH  operand A.
REQ-009 SHALL have port b  input  WIDTH  operand B.
REQ-010 SHALL have port use_acc  input  1  operand A taken from the internal accumulator instead of a.
REQ-011 SHALL have port out_valid  output  1  result available.
REQ-012 SHALL have port out_ready  input  1  consumer takes the result.
REQ-013 SHALL have port result  output  WIDTH  result low word.
REQ-014 SHALL have port result_hi  output  WIDTH  product high word; 0 for non-MUL operations.
REQ-015 SHALL have port flags  output  4  {N,V,C,Z}.
REQ-016 SHALL have port err  output  1  illegal or disabled opcode.

Function
REQ-017 SHALL implement FSM states IDLE, EXEC, MUL, DONE; in_ready = (state==IDLE).
REQ-018 SHALL accept a request on in_valid&&in_ready, registering op, operand A (a or acc) and b.
REQ-019 SHALL encode opcodes 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR logical, 7 SRA, 8 MUL unsigned; opcodes 9..15 are illegal.
REQ-020 SHALL route IDLE->EXEC->DONE for single-cycle ops, with out_valid asserted 2 cycles after accept.
REQ-021 SHALL route IDLE->MUL for MUL, run a shift-add for exactly WIDTH cycles, then enter DONE, with out_valid asserted WIDTH+1 cycles after accept.
REQ-022 SHALL hold result, result_hi, flags and err stable in DONE while out_ready=0, then return to IDLE the cycle after out_valid&&out_ready.
REQ-023 SHALL ignore in_valid outside IDLE; no request is queued.
REQ-024 SHALL set flags as follows: Z = full result (including result_hi for MUL) is 0; N = MSB of result (result_hi MSB for MUL); C = ADD carry-out, SUB borrow (a<b), shifts last bit shifted out, 0 when shift amount is 0, 0 otherwise; V = signed overflow for ADD/SUB, 0 otherwise.
REQ-025 SHALL, for an illegal opcode, report err=1, result=0, result_hi=0, flags=0, with the same timing as single-cycle ops.
REQ-026 SHALL load the accumulator with result on entry to DONE when err=0, and leave it unchanged when err=1.

Reset
REQ-027 SHALL, on rst=1 at a clock edge, set state=IDLE and clear accumulator, result, result_hi, flags, err and out_valid to 0, with in_ready=1 the following cycle.
REQ-028 SHALL abort any in-flight MUL or pending DONE result on reset, with no output produced.

Configuration
REQ-029 SHALL, when macro ALU_SEQ_MUL_EN is defined, include the MUL state and shift-add datapath.
REQ-030 SHALL, when ALU_SEQ_MUL_EN is undefined, treat opcode 8 as illegal (REQ-025), exclude the MUL state and datapath, and tie result_hi to 0.

Structure
REQ-031 SHALL place the opcode enum, FSM state enum and flag bit-index constants in shared package alu_seq_pkg.
REQ-032 SHALL implement the multiplier as sub-module alu_seq_mul (start/done, WIDTH-parametrised), instantiated only under ALU_SEQ_MUL_EN.

Verification (WIDTH=8)
REQ-033 SHALL cover: ADD a=0xFF b=0x01 -> result 0x00, Z=1, C=1, V=0, out_valid 2 cycles after accept.
REQ-034 SHALL cover: SUB a=0x80 b=0x01 -> result 0x7F, V=1, C=0, N=0.
REQ-035 SHALL cover: MUL 0xFF*0xFF -> result_hi 0xFE, result 0x01, out_valid exactly 9 cycles after accept, in_ready=0 throughout, and in_valid pulses during the operation ignored.
REQ-036 SHALL cover: ADD 5+3 -> 0x08, then ADD with use_acc=1 and b=0x02 -> 0x0A; an illegal op (0xF) -> err=1 with the accumulator still 0x0A.
REQ-037 SHALL cover: out_ready held low 3 cycles in DONE -> outputs stable; rst during MUL cycle 4 -> next cycle out_valid=0, in_ready=1, accumulator=0.
REQ-038 SHALL cover: build without ALU_SEQ_MUL_EN, op=8 -> err=1, result=0, out_valid 2 cycles after accept.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared opcode/state encodings and flag bit positions for the sequential ALU.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_SHL = 4'd5,
    OP_SHR = 4'd6,
    OP_SRA = 4'd7,
    OP_MUL = 4'd8
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } state_e;

  // flags port layout is {N,V,C,Z}
  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 2;
  localparam int unsigned FLAG_N = 3;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative shift-add unsigned multiplier: one partial-product step per cycle, WIDTH steps.
module alu_seq_mul #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] p;
  logic [2*WIDTH-1:0] p_next;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH:0]     sum;
  logic [CW-1:0]      cnt;
  logic               busy;

  // p holds {partial high, remaining multiplier bits}; product is the post-step value
  assign sum     = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, mcand} : '0);
  assign p_next  = {sum, p[WIDTH-1:1]};
  assign done    = busy && (cnt == CW'(WIDTH - 1));
  assign product = p_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      p     <= '0;
      mcand <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
    end else if (start) begin
      p     <= {{WIDTH{1'b0}}, b};
      mcand <= a;
      cnt   <= '0;
      busy  <= 1'b1;
    end else if (busy) begin
      p   <= p_next;
      cnt <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq_core.sv
// Sequential ALU with accumulator and valid/ready handshake.
// Define ALU_SEQ_MUL_EN to include the shift-add MUL path; otherwise opcode 8 is illegal.
module alu_seq_core
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             use_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [3:0]       flags,
  output logic             err
);

  state_e           state, state_n;
  op_e              op_q;
  logic [WIDTH-1:0] a_q, b_q, acc;
  logic             accept;

  logic [WIDTH:0]        add_w, sub_w, shl_w, shr_w;
  logic signed [WIDTH:0] sra_w;
  logic [SHW-1:0]        sh;
  logic [WIDTH-1:0]      alu_res;
  logic                  alu_c, alu_v, alu_err;
  logic [3:0]            exec_flags;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;

  // Shifts carry an extra guard bit so the last bit shifted out lands in bit WIDTH / bit 0
  assign sh    = b_q[SHW-1:0];
  assign add_w = {1'b0, a_q} + {1'b0, b_q};
  assign sub_w = {1'b0, a_q} - {1'b0, b_q};
  assign shl_w = {1'b0, a_q} << sh;
  assign shr_w = {a_q, 1'b0} >> sh;
  assign sra_w = $signed({a_q, 1'b0}) >>> sh;

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_err = 1'b0;
    case (op_q)
      OP_ADD: begin
        alu_res = add_w[WIDTH-1:0];
        alu_c   = add_w[WIDTH];
        alu_v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (alu_res[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_w[WIDTH-1:0];
        alu_c   = sub_w[WIDTH];
        alu_v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (alu_res[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_XOR: alu_res = a_q ^ b_q;
      OP_SHL: begin
        alu_res = shl_w[WIDTH-1:0];
        alu_c   = shl_w[WIDTH];
      end
      OP_SHR: begin
        alu_res = shr_w[WIDTH:1];
        alu_c   = shr_w[0];
      end
      OP_SRA: begin
        alu_res = sra_w[WIDTH:1];
        alu_c   = sra_w[0];
      end
      default: alu_err = 1'b1;
    endcase
    exec_flags         = '0;
    exec_flags[FLAG_N] = alu_res[WIDTH-1];
    exec_flags[FLAG_V] = alu_v;
    exec_flags[FLAG_C] = alu_c;
    exec_flags[FLAG_Z] = (alu_res == '0);
  end

`ifdef ALU_SEQ_MUL_EN
  logic                 mul_done;
  logic [2*WIDTH-1:0]   mul_prod;
  logic [WIDTH-1:0]     result_hi_q;
  logic [3:0]           mul_flags;

  alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (accept && (op == OP_MUL)),
    .a       (use_acc ? acc : a),
    .b       (b),
    .done    (mul_done),
    .product (mul_prod)
  );

  assign result_hi = result_hi_q;

  always_comb begin
    mul_flags         = '0;
    mul_flags[FLAG_N] = mul_prod[2*WIDTH-1];
    mul_flags[FLAG_Z] = (mul_prod == '0);
  end
`else
  assign result_hi = '0;
`endif

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (accept) begin
`ifdef ALU_SEQ_MUL_EN
          state_n = (op == OP_MUL) ? MUL : EXEC;
`else
          state_n = EXEC;
`endif
        end
      end
      EXEC: state_n = DONE;
`ifdef ALU_SEQ_MUL_EN
      MUL: if (mul_done) state_n = DONE;
`endif
      DONE: if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      op_q   <= OP_ADD;
      a_q    <= '0;
      b_q    <= '0;
      acc    <= '0;
      result <= '0;
      flags  <= '0;
      err    <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      result_hi_q <= '0;
`endif
    end else begin
      state <= state_n;
      if (accept) begin
        op_q <= op_e'(op);
        a_q  <= use_acc ? acc : a;
        b_q  <= b;
      end
      if (state == EXEC) begin
        result <= alu_res;
        flags  <= alu_err ? 4'b0000 : exec_flags;
        err    <= alu_err;
        if (!alu_err) acc <= alu_res;
`ifdef ALU_SEQ_MUL_EN
        result_hi_q <= '0;
`endif
      end
`ifdef ALU_SEQ_MUL_EN
      if (state == MUL && mul_done) begin
        result      <= mul_prod[WIDTH-1:0];
        result_hi_q <= mul_prod[2*WIDTH-1:WIDTH];
        flags       <= mul_flags;
        err         <= 1'b0;
        acc         <= mul_prod[WIDTH-1:0];
      end
`endif
    end
  end

endmodule

// File: tb/tb_alu_seq_core.sv
// Directed + random bench for alu_seq_core (WIDTH=8) against an arithmetic reference model.
// Expectations follow ALU_SEQ_MUL_EN the same way the design build does.
module tb_alu_seq_core;

  localparam int W = 8;
`ifdef ALU_SEQ_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   op = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         use_acc = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic [3:0]   flags;
  logic         err;

  int vectors = 0;
  int miscompares = 0;
  int acc_model = 0;

  typedef struct {
    int res;
    int hi;
    int flg;
    int er;
  } exp_t;

  alu_seq_core #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .use_acc   (use_acc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .result_hi (result_hi),
    .flags     (flags),
    .err       (err)
  );

  always #5 clk = ~clk;

  function automatic int sgn(input int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  function automatic exp_t model(input int opc, input int x, input int y);
    exp_t e;
    int sh, s, full, n, v, c, z;
    e = '{0, 0, 0, 0};
    sh = y % 8;
    v = 0;
    c = 0;
    case (opc)
      0: begin
        full = x + y; e.res = full % 256; c = (full > 255);
        s = sgn(x) + sgn(y); v = (s > 127 || s < -128);
      end
      1: begin
        e.res = (x - y + 256) % 256; c = (x < y);
        s = sgn(x) - sgn(y); v = (s > 127 || s < -128);
      end
      2: e.res = x & y;
      3: e.res = x | y;
      4: e.res = x ^ y;
      5: begin e.res = (x << sh) % 256; c = (sh == 0) ? 0 : (x >> (8 - sh)) & 1; end
      6: begin e.res = x >> sh; c = (sh == 0) ? 0 : (x >> (sh - 1)) & 1; end
      7: begin e.res = (sgn(x) >>> sh) & 255; c = (sh == 0) ? 0 : (x >> (sh - 1)) & 1; end
      default: begin
        if (opc == 8 && MUL_EN) begin
          full = x * y; e.res = full % 256; e.hi = full / 256;
          e.flg = ((e.hi >= 128) ? 8 : 0) | ((full == 0) ? 1 : 0);
          return e;
        end
        e.er = 1;
        return e;
      end
    endcase
    n = (e.res >= 128);
    z = (e.res == 0);
    e.flg = n * 8 + v * 4 + c * 2 + z;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    acc_model = 0;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_outputs", {result, result_hi, flags, err}, 0);
  endtask

  task automatic launch(input int opc, input int x, input int y, input bit ua);
    @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 1);
    in_valid = 1'b1;
    op = 4'(opc);
    a = W'(x);
    b = W'(y);
    use_acc = ua;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_op(input int opc, input int x, input int y, input bit ua,
                        input int hold, input bit poke);
    exp_t e;
    int lat;
    bit busy_bad;
    e = model(opc, ua ? acc_model : x, y);
    launch(opc, x, y, ua);
    lat = 1;
    busy_bad = 1'b0;
    while (!out_valid && lat < 40) begin
      if (in_ready) busy_bad = 1'b1;
      if (poke) begin
        in_valid = 1'b1;
        op = 4'($urandom_range(0, 15));
        a = W'($urandom);
        b = W'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, (opc == 8 && MUL_EN) ? W + 1 : 2);
    chk("in_ready_busy", 32'(busy_bad), 0);
    chk("result", 32'(result), e.res);
    chk("result_hi", 32'(result_hi), e.hi);
    chk("flags", 32'(flags), e.flg);
    chk("err", 32'(err), e.er);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_stable", {out_valid, in_ready, result, result_hi, flags, err},
          {1'b1, 1'b0, W'(e.res), W'(e.hi), 4'(e.flg), 1'(e.er)});
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("release_idle", {out_valid, in_ready}, 2'b01);
    if (e.er == 0) acc_model = e.res;
  endtask

  initial begin
    reset_dut();
    run_op(0, 8'hFF, 8'h01, 1'b0, 0, 1'b0);
    run_op(1, 8'h80, 8'h01, 1'b0, 0, 1'b0);
    run_op(0, 5, 3, 1'b0, 0, 1'b0);
    run_op(0, 0, 2, 1'b1, 0, 1'b0);
    run_op(15, 8'h12, 8'h34, 1'b0, 0, 1'b0);
    run_op(0, 0, 0, 1'b1, 0, 1'b0);
    run_op(8, 8'hFF, 8'hFF, 1'b0, 0, 1'b1);
    run_op(5, 8'hC3, 3, 1'b0, 3, 1'b0);
    run_op(7, 8'h81, 0, 1'b0, 1, 1'b0);
    run_op(1, 8'h10, 8'h20, 1'b0, 0, 1'b1);

    // reset while a result is pending in DONE
    launch(0, 8'h44, 8'h11, 1'b0);
    @(posedge clk); #1;
    chk("pending_valid", 32'(out_valid), 1);
    reset_dut();
    run_op(0, 0, 0, 1'b1, 0, 1'b0);

`ifdef ALU_SEQ_MUL_EN
    // reset during the 4th multiply cycle
    run_op(0, 8'h33, 0, 1'b0, 0, 1'b0);
    launch(8, 8'h0F, 8'h0F, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    reset_dut();
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid) break;
    end
    chk("no_output_after_abort", 32'(out_valid), 0);
    run_op(0, 0, 0, 1'b1, 0, 1'b0);
`endif

    for (int i = 0; i < 60; i++) begin
      run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
             int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
